// File: rtl/fp64_addsub_postnorm.sv
// ============================================================================
//  Module      : fp64_addsub_postnorm
//  Description : Signed add/subtract of two aligned double-precision
//                mantissas that share one exponent. The result is normalised
//                one shift per cycle and packed as an IEEE-754 double with
//                zero, overflow and underflow flags. Rounding is truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp64_addsub_postnorm #(
   parameter int MW   = 52,
   parameter int EW   = 11,
   parameter int EMAX = 2047
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           start,
   input  logic           sA,
   input  logic           sB,
   input  logic           op_sub,
   input  logic [MW:0]    Am,
   input  logic [MW:0]    Bm,
   input  logic [EW-1:0]  eSm,
   output logic           busy,
   output logic           done,
   output logic [EW+MW:0] result,
   output logic           zero,
   output logic           ovf,
   output logic           unf
);

   // One guard bit above the mantissa holds the carry of an addition.
   localparam logic [EW:0] C_EMAX  = (EW+1)'(EMAX);
   localparam logic [EW:0] C_E_ONE = (EW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_NORM = 2'd2,
      S_PACK = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_sa;
   logic            r_sb;
   logic            r_sub;
   logic [MW:0]     r_am;
   logic [MW:0]     r_bm;
   logic [EW-1:0]   r_es;
   logic [MW+1:0]   r_sum;
   logic [EW:0]     r_e;
   logic            r_sign;
   logic            r_busy;
   logic            r_done;
   logic [EW+MW:0]  r_result;
   logic            r_zero;
   logic            r_ovf;
   logic            r_unf;

   logic            w_eff;
   logic            w_a_ge_b;
   logic [MW+1:0]   w_sum;
   logic            w_sign;

   // Magnitude add/subtract of the latched operands, always yielding a
   // non-negative magnitude plus the sign it belongs to.
   always_comb begin
      w_eff    = r_sa ^ r_sb ^ r_sub;
      w_a_ge_b = (r_am >= r_bm);
      w_sum    = '0;
      w_sign   = r_sa;
      if (!w_eff) begin
         w_sum  = {1'b0, r_am} + {1'b0, r_bm};
         w_sign = r_sa;
      end else if (w_a_ge_b) begin
         w_sum  = {1'b0, r_am} - {1'b0, r_bm};
         w_sign = r_sa;
      end else begin
         w_sum  = {1'b0, r_bm} - {1'b0, r_am};
         w_sign = r_sb ^ r_sub;
      end
   end

   // Control FSM: latch, add, normalise one step per cycle, pack.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_sub    <= 1'b0;
         r_am     <= '0;
         r_bm     <= '0;
         r_es     <= '0;
         r_sum    <= '0;
         r_e      <= '0;
         r_sign   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else if (en) begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sa    <= sA;
                  r_sb    <= sB;
                  r_sub   <= op_sub;
                  r_am    <= Am;
                  r_bm    <= Bm;
                  r_es    <= eSm;
                  r_zero  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_unf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_ADD;
               end
            end
            S_ADD: begin
               r_sum <= w_sum;
               r_e   <= {1'b0, r_es};
               if (w_sum == '0) begin
                  // Exact cancellation always gives +0.
                  r_zero  <= 1'b1;
                  r_sign  <= 1'b0;
                  r_state <= S_PACK;
               end else begin
                  r_sign  <= w_sign;
                  r_state <= S_NORM;
               end
            end
            S_NORM: begin
               if (r_sum[MW+1]) begin
                  // Carry out of the add; the dropped LSB is truncated.
                  r_sum <= r_sum >> 1;
                  r_e   <= r_e + C_E_ONE;
               end else if (r_sum[MW]) begin
                  r_state <= S_PACK;
               end else if (r_e <= C_E_ONE) begin
                  // No room for another left shift: flush to signed zero.
                  r_unf   <= 1'b1;
                  r_state <= S_PACK;
               end else begin
                  r_sum <= r_sum << 1;
                  r_e   <= r_e - C_E_ONE;
               end
            end
            S_PACK: begin
               if (r_e >= C_EMAX) begin
                  r_result <= {r_sign, {EW{1'b1}}, {MW{1'b0}}};
                  r_ovf    <= 1'b1;
               end else if (r_unf) begin
                  r_result <= {r_sign, {(EW+MW){1'b0}}};
               end else if (r_zero) begin
                  r_result <= '0;
               end else begin
                  r_result <= {r_sign, r_e[EW-1:0], r_sum[MW-1:0]};
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign zero   = r_zero;
   assign ovf    = r_ovf;
   assign unf    = r_unf;

endmodule

`default_nettype wire

// File: doc/fp64_addsub_postnorm.md
Name: fp64_addsub_postnorm

Overview:
- Downstream neighbour of the 64-bit operand-alignment stage. It consumes two aligned 53-bit mantissas (hidden bit included) and the shared biased exponent.
- Performs the signed add/subtract of the magnitudes, then normalises iteratively with one shift per cycle.
- Packs an IEEE-754 double with zero, overflow and underflow flags.
- Multi-cycle FSM driven by the alignment stage's OE (done) indication.

Parameters:
- MW, 52, stored fraction width; mantissa inputs are MW+1 bits.
- EW, 11, exponent width.
- EMAX, 2047, all-ones exponent (infinity code).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  clock enable; when low, all state holds.
- start  in  1  operands valid (driven from upstream OE); sampled only in IDLE.
- sA  in  1  sign of operand A.
- sB  in  1  sign of operand B.
- op_sub  in  1  0 = A+B, 1 = A-B.
- Am  in  MW+1  aligned mantissa A.
- Bm  in  MW+1  aligned mantissa B.
- eSm  in  EW  shared biased exponent.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  64  packed {sign, exp[10:0], frac[51:0]}; holds until the next done.
- zero  out  1  result is +0 (exact cancellation); valid with done, held.
- ovf  out  1  result is infinity; valid with done, held.
- unf  out  1  flushed to zero on exponent underflow; valid with done, held.

Behaviour:
- Reset (synchronous, active-high) takes priority over en:
  - state = IDLE.
  - result = 0; done, busy, zero, ovf, unf = 0.
  - All internal registers cleared.
  - A reset mid-operation abandons the operation with no done.
- en = 0 freezes the FSM and all registers. done stays at its current value (the pulse is stretched, not lost). start is ignored while en = 0.
- States: IDLE, ADD, NORM, PACK.
- IDLE:
  - On start = 1 and en = 1: latch sA, sB, op_sub, Am, Bm and eSm, then go to ADD.
  - A start seen in any other state is ignored and not queued.
- ADD (one cycle):
  - Effective subtract eff = sA ^ sB ^ op_sub.
  - eff = 0: sum[53:0] = Am + Bm; sign = sA.
  - eff = 1, Am >= Bm: sum = Am - Bm; sign = sA.
  - eff = 1, Am < Bm: sum = Bm - Am; sign = ~sA if op_sub = 0, else ~sB... simplified rule: sign = sB ^ op_sub.
  - Exponent register e = eSm, widened internally to EW+1 bits.
  - If sum == 0: set zero = 1 and sign = 0, then go to PACK. Otherwise go to NORM.
- NORM (one action per cycle):
  - sum[53] = 1: sum >>= 1, e += 1. The shifted-out bit is truncated.
  - else sum[52] = 1: normalised, go to PACK.
  - else e <= 1: set unf = 1, go to PACK. The result is ±0 with the computed sign.
  - else: sum <<= 1, e -= 1.
- PACK (one cycle):
  - e >= EMAX: result = {sign, 11'h7FF, 52'b0}; ovf = 1.
  - unf: result = {sign, 63'b0}.
  - zero: result = 64'b0.
  - otherwise: result = {sign, e[10:0], sum[51:0]}.
  - Pulse done = 1 for one enabled cycle; busy drops; go to IDLE.
  - The zero, ovf and unf flags are cleared when the next start is accepted.
- Rounding is truncation only; round-to-nearest is out of scope.
- Latency, counted from the start-accept edge to done high: 3 + k cycles, where k is the number of NORM shifts. An exact cancellation takes 2 cycles. The maximum is 3 + 52 cycles.
- Inputs are don't-care after the start-accept edge.

Test Plan:
- 1.0+1.0: sA=sB=0, op_sub=0, Am=Bm=1<<52, eSm=0x3FF -> result 0x4000000000000000 with done after 4 cycles; zero, ovf and unf all 0.
- 1.0-0.75: Am=1<<52, Bm=3<<50, eSm=0x3FF, op_sub=1 -> two left shifts; result 0x3FD0000000000000 after 5 cycles.
- 1.5-1.5: Am=Bm=3<<51, op_sub=1 -> result 0x0 and zero=1 after 2 cycles; the negative-operand variant (sA=sB=1) also yields +0.
- Overflow: Am=Bm=1<<52, eSm=0x7FE, add -> result 0x7FF0000000000000, ovf=1 after 4 cycles. Sign/magnitude: sA=0, op_sub=0, sB=1, Am=1<<52, Bm=3<<51 -> result 0xBFE0000000000000 (-0.5).
- Underflow: Am=(1<<52)+1, Bm=1<<52, eSm=0x005, sub -> unf=1, result 0x0 with the computed sign.
- Control: a second start while busy produces exactly one done; en held low for 3 cycles mid-NORM stretches latency by 3; rst asserted in NORM returns to IDLE with result=0, busy=0 and no done.
